// File: rtl/cdb_arbiter_if.sv
// Result handoff from execution units into the CDB arbiter, and the registered
// CDB broadcast back out to the ROB and reservation stations.
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_BIT = 2,
    parameter int ROB_BIT = 5
);
    logic [NUM_SRC-1:0]         req_valid;
    logic [NUM_SRC-1:0]         req_ready;
    logic [NUM_SRC*ROB_BIT-1:0] req_entry;
    logic [NUM_SRC*32-1:0]      req_value;
    logic [NUM_SRC*32-1:0]      req_next_pc;

    logic                       cdb_valid;
    logic [ROB_BIT-1:0]         cdb_entry;
    logic [31:0]                cdb_value;
    logic [31:0]                cdb_next_pc;
    logic [SRC_BIT-1:0]         cdb_src;

    modport master (
        output req_valid, req_entry, req_value, req_next_pc,
        input  req_ready,
        input  cdb_valid, cdb_entry, cdb_value, cdb_next_pc, cdb_src
    );

    modport slave (
        input  req_valid, req_entry, req_value, req_next_pc,
        output req_ready,
        output cdb_valid, cdb_entry, cdb_value, cdb_next_pc, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among execution units, with a
// one-entry holding slot per unit and a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_BIT = 2,
    parameter int ROB_BIT = 5
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush,
    cdb_arbiter_if.slave    bus
);

    logic [NUM_SRC-1:0]              hold_valid_q, hold_valid_d;
    logic [NUM_SRC-1:0][ROB_BIT-1:0] hold_entry_q, hold_entry_d;
    logic [NUM_SRC-1:0][31:0]        hold_value_q, hold_value_d;
    logic [NUM_SRC-1:0][31:0]        hold_next_pc_q, hold_next_pc_d;
    logic [SRC_BIT-1:0]              rr_ptr_q, rr_ptr_d;

    logic                            cdb_valid_q, cdb_valid_d;
    logic [ROB_BIT-1:0]              cdb_entry_q, cdb_entry_d;
    logic [31:0]                     cdb_value_q, cdb_value_d;
    logic [31:0]                     cdb_next_pc_q, cdb_next_pc_d;
    logic [SRC_BIT-1:0]              cdb_src_q, cdb_src_d;

    logic                            grant_vld;
    logic [SRC_BIT-1:0]              grant_idx;
    logic [NUM_SRC-1:0]              grant_oh;
    logic [NUM_SRC-1:0]              req_ready;
    logic [NUM_SRC-1:0]              accept;

    function automatic logic [SRC_BIT-1:0] scan_idx(input logic [SRC_BIT-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SRC_BIT'(s);
    endfunction

    // Scanning downward lets the slot closest to rr_ptr overwrite the others.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hold_valid_q[scan_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx(rr_ptr_q, k);
            end
        end
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    // A slot draining this cycle can take a new result on the same edge.
    assign req_ready     = {NUM_SRC{rst_in && rdy_in && !flush}} & (~hold_valid_q | grant_oh);
    assign accept        = bus.req_valid & req_ready;
    assign bus.req_ready = req_ready;

    always_comb begin
        hold_valid_d   = hold_valid_q;
        hold_entry_d   = hold_entry_q;
        hold_value_d   = hold_value_q;
        hold_next_pc_d = hold_next_pc_q;
        rr_ptr_d       = rr_ptr_q;
        cdb_valid_d    = cdb_valid_q;
        cdb_entry_d    = cdb_entry_q;
        cdb_value_d    = cdb_value_q;
        cdb_next_pc_d  = cdb_next_pc_q;
        cdb_src_d      = cdb_src_q;

        if (rdy_in) begin
            if (flush) begin
                hold_valid_d = '0;
                cdb_valid_d  = 1'b0;
            end else begin
                cdb_valid_d = grant_vld;
                if (grant_vld) begin
                    cdb_entry_d             = hold_entry_q[grant_idx];
                    cdb_value_d             = hold_value_q[grant_idx];
                    cdb_next_pc_d           = hold_next_pc_q[grant_idx];
                    cdb_src_d               = grant_idx;
                    hold_valid_d[grant_idx] = 1'b0;
                    rr_ptr_d = (grant_idx == SRC_BIT'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (accept[i]) begin
                        hold_valid_d[i]   = 1'b1;
                        hold_entry_d[i]   = bus.req_entry[i*ROB_BIT +: ROB_BIT];
                        hold_value_d[i]   = bus.req_value[i*32 +: 32];
                        hold_next_pc_d[i] = bus.req_next_pc[i*32 +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hold_valid_q   <= '0;
            hold_entry_q   <= '0;
            hold_value_q   <= '0;
            hold_next_pc_q <= '0;
            rr_ptr_q       <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_entry_q    <= '0;
            cdb_value_q    <= '0;
            cdb_next_pc_q  <= '0;
            cdb_src_q      <= '0;
        end else begin
            hold_valid_q   <= hold_valid_d;
            hold_entry_q   <= hold_entry_d;
            hold_value_q   <= hold_value_d;
            hold_next_pc_q <= hold_next_pc_d;
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_entry_q    <= cdb_entry_d;
            cdb_value_q    <= cdb_value_d;
            cdb_next_pc_q  <= cdb_next_pc_d;
            cdb_src_q      <= cdb_src_d;
        end
    end

    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_entry   = cdb_entry_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.cdb_next_pc = cdb_next_pc_q;
    assign bus.cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: expected broadcasts are queued as requests are driven
// and popped when a fresh CDB broadcast appears.
module tb_cdb_arbiter;

    typedef struct packed {
        logic [1:0]  src;
        logic [4:0]  entry;
        logic [31:0] value;
        logic [31:0] npc;
    } bc_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;
    logic last_rst = 1'b0;
    logic last_rdy = 1'b0;

    int   n_tests = 0;
    int   n_fail  = 0;
    bc_t  sb_q[$];

    cdb_arbiter_if #(.NUM_SRC(4), .SRC_BIT(2), .ROB_BIT(5)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .SRC_BIT(2), .ROB_BIT(5)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        last_rst <= rst_in;
        last_rdy <= rdy_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A broadcast is new only if the previous edge was a live, unpaused one.
    always @(negedge clk_in) begin
        if (last_rst && last_rdy && bus.cdb_valid === 1'b1) begin
            chk("bc_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                bc_t e;
                e = sb_q.pop_front();
                chk("bc_src",   32'(bus.cdb_src),   32'(e.src));
                chk("bc_entry", 32'(bus.cdb_entry), 32'(e.entry));
                chk("bc_value", bus.cdb_value,      e.value);
                chk("bc_npc",   bus.cdb_next_pc,    e.npc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_in);
    endtask

    task automatic clr_req();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int src, input logic [4:0] e, input logic [31:0] v,
                           input logic [31:0] npc, input bit push);
        bc_t b;
        bus.req_valid[src]            = 1'b1;
        bus.req_entry[src*5 +: 5]     = e;
        bus.req_value[src*32 +: 32]   = v;
        bus.req_next_pc[src*32 +: 32] = npc;
        if (push) begin
            b.src   = 2'(src);
            b.entry = e;
            b.value = v;
            b.npc   = npc;
            sb_q.push_back(b);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        chk("drain", 32'(sb_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid   = 4'hF;
        bus.req_entry   = 20'hABCDE;
        bus.req_value   = {4{32'hDEAD_BEEF}};
        bus.req_next_pc = {4{32'h0000_4444}};

        // reset held two cycles with all sources requesting
        tick();
        at_neg();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst_entry", 32'(bus.cdb_entry), 32'd0);
        chk("rst_value", bus.cdb_value, 32'd0);
        chk("rst_npc",   bus.cdb_next_pc, 32'd0);
        chk("rst_src",   32'(bus.cdb_src), 32'd0);
        tick();
        at_neg();
        chk("rst_ready2", 32'(bus.req_ready), 32'd0);
        chk("rst_valid2", 32'(bus.cdb_valid), 32'd0);

        // single ALU result, two-cycle latency, one-cycle pulse
        tick();
        rst_in = 1'b1;
        clr_req();
        set_req(0, 5'd5, 32'h1234_5678, 32'h0, 1'b1);
        at_neg();
        chk("ready_after_rst", 32'(bus.req_ready), 32'hF);
        tick();
        clr_req();
        at_neg();
        chk("lat_c1", 32'(bus.cdb_valid), 32'd0);
        tick();
        at_neg();
        chk("lat_c2", 32'(bus.cdb_valid), 32'd1);
        tick();
        at_neg();
        chk("single_drop", 32'(bus.cdb_valid), 32'd0);
        tick();

        // JAL alone: rr_ptr 1 -> grant 3 -> wraps to 0
        set_req(3, 5'd6, 32'hA5A5_0003, 32'h0000_1000, 1'b1);
        tick();
        clr_req();
        wait_drain();

        // four-way contention from rr_ptr 0
        for (int i = 0; i < 4; i++)
            set_req(i, 5'(i + 1), 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 1'b1);
        at_neg();
        chk("cont_ready0", 32'(bus.req_ready), 32'hF);
        tick();
        clr_req();
        at_neg();
        chk("cont_ready1", 32'(bus.req_ready), 32'h1);
        tick();
        at_neg();
        chk("cont_ready2", 32'(bus.req_ready), 32'h3);
        tick();
        at_neg();
        chk("cont_ready3", 32'(bus.req_ready), 32'h7);
        tick();
        at_neg();
        chk("cont_ready4", 32'(bus.req_ready), 32'hF);
        wait_drain();

        // ALU back-to-back: slot drains and reloads on the same edge
        for (int i = 0; i < 3; i++) begin
            set_req(0, 5'(11 + i), 32'hB000 + 32'(i), 32'h0, 1'b1);
            at_neg();
            chk("b2b_ready", 32'(bus.req_ready[0]), 32'd1);
            tick();
        end
        clr_req();
        wait_drain();

        // rr_ptr 1 -> grant BR -> rr_ptr 3, then slots 0 and 3: 3 first, then 0
        set_req(2, 5'd14, 32'h1, 32'h0000_5000, 1'b1);
        tick();
        clr_req();
        wait_drain();
        set_req(3, 5'd15, 32'hC0DE_0003, 32'h0000_6000, 1'b1);
        set_req(0, 5'd16, 32'hC0DE_0000, 32'h0, 1'b1);
        tick();
        clr_req();
        wait_drain();
        // rr_ptr now 1: LSB ahead of ALU
        set_req(1, 5'd17, 32'hD1, 32'h0, 1'b1);
        set_req(0, 5'd18, 32'hD0, 32'h0, 1'b1);
        tick();
        clr_req();
        wait_drain();

        // flush with slots 1 and 2 full and LSB requesting
        set_req(1, 5'd19, 32'hF1, 32'h0, 1'b0);
        set_req(2, 5'd20, 32'hF2, 32'h0, 1'b0);
        tick();
        clr_req();
        set_req(1, 5'd21, 32'hF3, 32'h0, 1'b0);
        flush = 1'b1;
        at_neg();
        chk("flush_ready", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0;
        clr_req();
        at_neg();
        chk("flush_nobc", 32'(bus.cdb_valid), 32'd0);
        chk("flush_empty", 32'(bus.req_ready), 32'hF);
        tick();
        tick();
        tick();
        set_req(1, 5'd22, 32'hE1, 32'h0, 1'b1);
        set_req(0, 5'd23, 32'hE0, 32'h0, 1'b1);
        tick();
        clr_req();
        wait_drain();

        // pause while entry 7 is on the bus, slots 0 and 3 waiting at rr_ptr 3
        set_req(2, 5'd7, 32'h77, 32'h0000_3000, 1'b1);
        tick();
        clr_req();
        set_req(3, 5'd9, 32'h99, 32'h0000_7000, 1'b1);
        set_req(0, 5'd8, 32'h88, 32'h0, 1'b1);
        tick();
        clr_req();
        rdy_in = 1'b0;
        set_req(1, 5'd10, 32'hAA, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("pause_valid", 32'(bus.cdb_valid), 32'd1);
            chk("pause_entry", 32'(bus.cdb_entry), 32'd7);
            chk("pause_value", bus.cdb_value, 32'h77);
            chk("pause_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        rdy_in = 1'b1;
        clr_req();
        wait_drain();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the execution units (ALU, LSB, branch unit, JAL/JALR unit) that complete instructions for the reorder buffer. Each unit hands its result over with a valid/ready handshake into a one-entry holding slot. The arbiter grants one slot per cycle and drives a registered broadcast of ROB entry, value and next PC to the ROB and the reservation stations. A flush input discards all pending results on misprediction recovery.

## Interface
- NUM_SRC, 4, number of requesting units; index 0 = ALU, 1 = LSB, 2 = BR, 3 = JAL/JALR.
- SRC_BIT, 2, width of source index; NUM_SRC <= 2^SRC_BIT.
- ROB_BIT, 5, width of a ROB entry index.

Ports:
- clk_in  in  1  system clock; one clock domain.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global ready; when low, block holds all state.
- flush  in  1  discard all pending and in-flight results (mispredict recovery).
- req_valid  in  NUM_SRC  per-source result valid.
- req_ready  out  NUM_SRC  per-source slot can accept this cycle.
- req_entry  in  NUM_SRC*ROB_BIT  per-source ROB entry; source i at [i*ROB_BIT +: ROB_BIT].
- req_value  in  NUM_SRC*32  per-source result value / branch taken flag.
- req_next_pc  in  NUM_SRC*32  per-source resolved next PC (BR, JALR; 0 otherwise).
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_entry  out  ROB_BIT  broadcast ROB entry.
- cdb_value  out  32  broadcast value.
- cdb_next_pc  out  32  broadcast next PC.
- cdb_src  out  SRC_BIT  index of the granted source.

## Operation
- Per source i, a holding slot: hold_valid[i], hold_entry[i], hold_value[i], hold_next_pc[i].
- req_ready[i] = rst_in && rdy_in && !flush && (!hold_valid[i] || grant[i]). This is combinational; it permits back-to-back transfers when the slot drains in the same cycle.
- Accept: on an edge with req_valid[i] && req_ready[i], the slot loads the source's fields and hold_valid[i] is set.
- Grant (combinational): scan slots from rr_ptr upward, modulo NUM_SRC. The first slot with hold_valid set is granted. If no slot is valid, nothing is granted.
- On an edge with a grant g:
  - cdb_valid <= 1; cdb_entry/value/next_pc <= slot g; cdb_src <= g.
  - hold_valid[g] cleared unless reloaded in the same edge.
  - rr_ptr <= (g+1) mod NUM_SRC.
- On an edge with no grant: cdb_valid <= 0; data outputs keep their old values; rr_ptr unchanged.
- Flush: all hold_valid <= 0 and cdb_valid <= 0. Data outputs and rr_ptr are unchanged. No requests are accepted in the flush cycle.
- rdy_in low: all registers hold, including cdb_valid and rr_ptr. req_ready = 0.
- Priority at an edge: reset > rdy_in low > flush > normal operation.

## Timing
- Reset (rst_in low at an edge): hold_valid = 0, rr_ptr = 0, cdb_valid = 0, cdb_entry = 0, cdb_value = 0, cdb_next_pc = 0, cdb_src = 0. req_ready = 0 while rst_in is low.
- Latency: a handshake in cycle c puts the result in the slot in cycle c+1. Uncontended, cdb_valid is asserted in cycle c+2.
- Throughput: one broadcast per cycle; each source can sustain one transfer per cycle while it is granted every cycle.
- Fairness: a valid slot is granted within NUM_SRC cycles (no starvation).
- cdb_valid is high for exactly one cycle per granted result, except that it holds while rdy_in is low.
- Simultaneous accept and grant of the same slot: the old content is broadcast and the new content is retained.
- rr_ptr wrap: after granting NUM_SRC-1, rr_ptr becomes 0.

## Test plan
- Reset: hold rst_in low 2 cycles with req_valid = 4'b1111 -> req_ready = 0, cdb_valid = 0, all outputs 0. After release, the first accept is broadcast 2 cycles later.
- Single source: ALU sends entry 5, value 0x12345678 in cycle 3 -> cdb_valid = 1 in cycle 5 with entry 5, value 0x12345678, cdb_src = 0, then cdb_valid = 0 in cycle 6.
- Contention: all four sources valid in the same cycle with entries 1, 2, 3, 4 and rr_ptr = 0 -> broadcasts in order src 0, 1, 2, 3 on consecutive cycles. req_ready[3] stays low until its slot drains.
- Round-robin wrap: rr_ptr = 3 with slots 0 and 3 valid -> grant 3 then 0, after which rr_ptr = 1.
- Flush: slots 1 and 2 full, flush pulsed with LSB req_valid high -> no broadcast next cycle, both slots empty, LSB request not accepted, rr_ptr unchanged.
- Pause: rdy_in low for 3 cycles while cdb_valid = 1 with entry 7 -> outputs frozen and req_ready = 0. On resume, arbitration continues from the same rr_ptr.
